// File: rtl/ex_muldiv_ctrl_if.sv
// EX-stage <-> multiply/divide sequencer bus.
// The master side is the EX stage (operands, opcode, flush); the slave side
// is the sequencer (stall, busy and the result returned toward EX/MEM).
interface ex_muldiv_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              ex_valid_i;
    logic [10:0]       ex_opcode_i;
    logic [ADDR_W-1:0] ex_waddr_i;
    logic [DATA_W-1:0] ex_reg1_i;
    logic [DATA_W-1:0] ex_reg2_i;
    logic              flush_i;
    logic              stall_o;
    logic              busy_o;
    logic              md_valid_o;
    logic [DATA_W-1:0] md_result_o;
    logic [ADDR_W-1:0] md_waddr_o;
    logic              md_dbz_o;

    modport master (
        output ex_valid_i, ex_opcode_i, ex_waddr_i, ex_reg1_i, ex_reg2_i, flush_i,
        input  stall_o, busy_o, md_valid_o, md_result_o, md_waddr_o, md_dbz_o
    );

    modport slave (
        input  ex_valid_i, ex_opcode_i, ex_waddr_i, ex_reg1_i, ex_reg2_i, flush_i,
        output stall_o, busy_o, md_valid_o, md_result_o, md_waddr_o, md_dbz_o
    );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Multi-cycle MUL / UDIV sequencer for the EX stage.
// One bit per cycle: shift-add multiply (low half only) and restoring
// unsigned divide. Operand registers are shared between the two ops:
//   a_r   : multiplicand, or dividend that fills with quotient bits from the LSB
//   b_r   : multiplier (shifts right), or divisor (static)
//   acc_r : product accumulator, or partial remainder
module ex_muldiv_ctrl #(
    parameter int          DATA_W   = 64,
    parameter int          ADDR_W   = 5,
    parameter logic [10:0] OPC_MUL  = 11'h4D8,
    parameter logic [10:0] OPC_UDIV = 11'h4D6
) (
    input  logic           clock,
    input  logic           reset,
    ex_muldiv_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [DATA_W-1:0] a_r, a_nxt_s;
    logic [DATA_W-1:0] b_r, b_nxt_s;
    logic [DATA_W-1:0] acc_r, acc_nxt_s;
    logic [ADDR_W-1:0] op_waddr_r, op_waddr_nxt_s;
    logic [DATA_W-1:0] md_result_r, md_result_nxt_s;
    logic [ADDR_W-1:0] md_waddr_r, md_waddr_nxt_s;
    logic              md_dbz_r, md_dbz_nxt_s;

    logic              is_mul_s, is_div_s, start_s, last_iter_s;
    logic [DATA_W-1:0] mul_sum_s;
    logic [DATA_W:0]   div_shift_s;
    logic              div_ge_s;
    logic [DATA_W-1:0] div_diff_s, rem_nxt_s, quo_nxt_s;

    assign is_mul_s    = (bus.ex_opcode_i == OPC_MUL);
    assign is_div_s    = (bus.ex_opcode_i == OPC_UDIV);
    // Gated by reset so that stall_o is low for as long as reset is held.
    assign start_s     = bus.ex_valid_i & (is_mul_s | is_div_s) & (state_r == ST_IDLE)
                         & ~bus.flush_i & reset;
    assign last_iter_s = (cnt_r == CNT_W'(1));

    // Shift-add step: add the multiplicand when the current multiplier bit is set.
    assign mul_sum_s   = acc_r + (b_r[0] ? a_r : {DATA_W{1'b0}});

    // Restoring-divide step: bring down the dividend MSB, subtract if it fits.
    // When div_ge_s holds the difference fits in DATA_W bits, so the
    // subtraction is done at DATA_W width.
    assign div_shift_s = {acc_r, a_r[DATA_W-1]};
    assign div_ge_s    = (div_shift_s >= {1'b0, b_r});
    assign div_diff_s  = div_shift_s[DATA_W-1:0] - b_r;
    assign rem_nxt_s   = div_ge_s ? div_diff_s : div_shift_s[DATA_W-1:0];
    assign quo_nxt_s   = {a_r[DATA_W-2:0], div_ge_s};

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; flush aborts from any state.
    always_comb begin
        state_nxt_s = state_r;
        if (bus.flush_i) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        if (is_mul_s) begin
                            state_nxt_s = ST_MUL;
                        end else if (bus.ex_reg2_i == {DATA_W{1'b0}}) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_DIV;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (last_iter_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_DONE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Datapath next values; result registers load only on entry to DONE.
    always_comb begin
        cnt_nxt_s       = cnt_r;
        a_nxt_s         = a_r;
        b_nxt_s         = b_r;
        acc_nxt_s       = acc_r;
        op_waddr_nxt_s  = op_waddr_r;
        md_result_nxt_s = md_result_r;
        md_waddr_nxt_s  = md_waddr_r;
        md_dbz_nxt_s    = md_dbz_r;
        if (bus.flush_i) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        a_nxt_s        = bus.ex_reg1_i;
                        b_nxt_s        = bus.ex_reg2_i;
                        acc_nxt_s      = {DATA_W{1'b0}};
                        cnt_nxt_s      = CNT_W'(DATA_W);
                        op_waddr_nxt_s = bus.ex_waddr_i;
                        if (is_div_s && (bus.ex_reg2_i == {DATA_W{1'b0}})) begin
                            md_result_nxt_s = {DATA_W{1'b0}};
                            md_waddr_nxt_s  = bus.ex_waddr_i;
                            md_dbz_nxt_s    = 1'b1;
                        end else begin
                            md_dbz_nxt_s    = md_dbz_r;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                ST_MUL: begin
                    acc_nxt_s = mul_sum_s;
                    a_nxt_s   = {a_r[DATA_W-2:0], 1'b0};
                    b_nxt_s   = {1'b0, b_r[DATA_W-1:1]};
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                    if (last_iter_s) begin
                        md_result_nxt_s = mul_sum_s;
                        md_waddr_nxt_s  = op_waddr_r;
                        md_dbz_nxt_s    = 1'b0;
                    end else begin
                        md_dbz_nxt_s    = md_dbz_r;
                    end
                end
                ST_DIV: begin
                    acc_nxt_s = rem_nxt_s;
                    a_nxt_s   = quo_nxt_s;
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                    if (last_iter_s) begin
                        md_result_nxt_s = quo_nxt_s;
                        md_waddr_nxt_s  = op_waddr_r;
                        md_dbz_nxt_s    = 1'b0;
                    end else begin
                        md_dbz_nxt_s    = md_dbz_r;
                    end
                end
                ST_DONE: cnt_nxt_s = cnt_r;
                default: cnt_nxt_s = {CNT_W{1'b0}};
            endcase
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r       <= {CNT_W{1'b0}};
            a_r         <= {DATA_W{1'b0}};
            b_r         <= {DATA_W{1'b0}};
            acc_r       <= {DATA_W{1'b0}};
            op_waddr_r  <= {ADDR_W{1'b0}};
            md_result_r <= {DATA_W{1'b0}};
            md_waddr_r  <= {ADDR_W{1'b0}};
            md_dbz_r    <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            a_r         <= a_nxt_s;
            b_r         <= b_nxt_s;
            acc_r       <= acc_nxt_s;
            op_waddr_r  <= op_waddr_nxt_s;
            md_result_r <= md_result_nxt_s;
            md_waddr_r  <= md_waddr_nxt_s;
            md_dbz_r    <= md_dbz_nxt_s;
        end
    end

    assign bus.stall_o     = start_s | (state_r == ST_MUL) | (state_r == ST_DIV);
    assign bus.busy_o      = (state_r == ST_MUL) | (state_r == ST_DIV);
    assign bus.md_valid_o  = (state_r == ST_DONE) & ~bus.flush_i;
    assign bus.md_result_o = md_result_r;
    assign bus.md_waddr_o  = md_waddr_r;
    assign bus.md_dbz_o    = md_dbz_r;
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: a vector table of MUL/UDIV operations
// with hand-computed results and latencies, plus sequences for back-to-back
// issue, non-muldiv opcodes, flush and asynchronous reset.
module tb_ex_muldiv_ctrl;
    localparam int          DATA_W   = 64;
    localparam int          ADDR_W   = 5;
    localparam logic [10:0] OPC_MUL  = 11'h4D8;
    localparam logic [10:0] OPC_UDIV = 11'h4D6;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    ex_muldiv_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    ex_muldiv_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OPC_MUL(OPC_MUL), .OPC_UDIV(OPC_UDIV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [10:0] opc;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  waddr;
        logic [63:0] exp_res;
        logic        exp_dbz;
        int          exp_lat;   // cycles from start cycle to md_valid cycle
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.ex_valid_i  = 1'b0;
        bus.ex_opcode_i = 11'h000;
        bus.ex_waddr_i  = 5'd0;
        bus.ex_reg1_i   = 64'd0;
        bus.ex_reg2_i   = 64'd0;
        bus.flush_i     = 1'b0;
    endtask

    // Issue one op, hold it while stalled, check result, latency and stall/busy counts.
    task automatic run_vec(input vec_t v);
        int stalls;
        int busys;
        int cyc;
        bit seen;
        @(negedge clock);
        bus.ex_valid_i  = 1'b1;
        bus.ex_opcode_i = v.opc;
        bus.ex_reg1_i   = v.a;
        bus.ex_reg2_i   = v.b;
        bus.ex_waddr_i  = v.waddr;
        #1;
        stalls = 0; busys = 0; cyc = 0; seen = 1'b0;
        while (!seen && cyc < 200) begin
            if (bus.stall_o) stalls++;
            if (bus.busy_o) busys++;
            if (bus.md_valid_o) begin
                seen = 1'b1;
                chk({v.name, "_stall_in_done"}, {63'd0, bus.stall_o}, 64'd0);
                chk({v.name, "_result"}, bus.md_result_o, v.exp_res);
                chk({v.name, "_waddr"}, {59'd0, bus.md_waddr_o}, {59'd0, v.waddr});
                chk({v.name, "_dbz"}, {63'd0, bus.md_dbz_o}, {63'd0, v.exp_dbz});
                bus.ex_valid_i = 1'b0;
            end else begin
                @(negedge clock);
                #1;
                cyc++;
            end
        end
        chk({v.name, "_valid_seen"}, {63'd0, seen}, 64'd1);
        chk({v.name, "_latency"}, 64'(cyc), 64'(v.exp_lat));
        chk({v.name, "_stall_cycles"}, 64'(stalls), 64'(v.exp_lat));
        chk({v.name, "_busy_cycles"}, 64'(busys), 64'(v.exp_lat - 1));
        @(negedge clock);
        #1;
        chk({v.name, "_valid_pulse"}, {63'd0, bus.md_valid_o}, 64'd0);
        chk({v.name, "_idle_stall"}, {63'd0, bus.stall_o}, 64'd0);
        chk({v.name, "_result_hold"}, bus.md_result_o, v.exp_res);
    endtask

    initial begin
        int cyc;
        int nvalid;
        vec_t v;
        checks = 0;
        errors = 0;

        vecs[0] = '{"mul_3x5",     OPC_MUL,  64'd3, 64'd5, 5'd9, 64'd15, 1'b0, 65};
        vecs[1] = '{"mul_wrap",    OPC_MUL,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 65};
        vecs[2] = '{"div_100_7",   OPC_UDIV, 64'd100, 64'd7, 5'd3, 64'd14, 1'b0, 65};
        vecs[3] = '{"div_by_zero", OPC_UDIV, 64'd5, 64'd0, 5'd4, 64'd0, 1'b1, 1};
        vecs[4] = '{"mul_shift",   OPC_MUL,  64'h1234_5678, 64'h1000, 5'd31,
                    64'h0000_0123_4567_8000, 1'b0, 65};
        vecs[5] = '{"div_max_1",   OPC_UDIV, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd7,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65};
        vecs[6] = '{"div_small",   OPC_UDIV, 64'd7, 64'd100, 5'd2, 64'd0, 1'b0, 65};
        vecs[7] = '{"div_max_max", OPC_UDIV, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h8000_0000_0000_0000, 5'd12, 64'd1, 1'b0, 65};

        // Reset state.
        reset = 1'b0;
        idle_inputs();
        #3;
        chk("rst_stall",  {63'd0, bus.stall_o}, 64'd0);
        chk("rst_busy",   {63'd0, bus.busy_o}, 64'd0);
        chk("rst_valid",  {63'd0, bus.md_valid_o}, 64'd0);
        chk("rst_result", bus.md_result_o, 64'd0);
        chk("rst_waddr",  {59'd0, bus.md_waddr_o}, 64'd0);
        chk("rst_dbz",    {63'd0, bus.md_dbz_o}, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Table-driven ops.
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Non-muldiv opcode: no stall, no busy, no result.
        @(negedge clock);
        bus.ex_valid_i  = 1'b1;
        bus.ex_opcode_i = 11'h550;
        bus.ex_reg1_i   = 64'd3;
        bus.ex_reg2_i   = 64'd5;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("other_stall", {63'd0, bus.stall_o}, 64'd0);
            chk("other_busy",  {63'd0, bus.busy_o}, 64'd0);
            chk("other_valid", {63'd0, bus.md_valid_o}, 64'd0);
            @(negedge clock);
        end
        idle_inputs();

        // Back-to-back: an op held through DONE is re-accepted one cycle later.
        @(negedge clock);
        bus.ex_valid_i  = 1'b1;
        bus.ex_opcode_i = OPC_MUL;
        bus.ex_reg1_i   = 64'd2;
        bus.ex_reg2_i   = 64'd3;
        bus.ex_waddr_i  = 5'd6;
        #1;
        cyc = 0;
        while (!bus.md_valid_o && cyc < 200) begin
            @(negedge clock);
            #1;
            cyc++;
        end
        chk("b2b_done",       {63'd0, bus.md_valid_o}, 64'd1);
        chk("b2b_result",     bus.md_result_o, 64'd6);
        chk("b2b_done_stall", {63'd0, bus.stall_o}, 64'd0);
        @(negedge clock);
        #1;
        chk("b2b_bubble_busy",   {63'd0, bus.busy_o}, 64'd0);
        chk("b2b_restart_stall", {63'd0, bus.stall_o}, 64'd1);
        @(negedge clock);
        #1;
        chk("b2b_restart_busy",  {63'd0, bus.busy_o}, 64'd1);
        bus.flush_i    = 1'b1;
        bus.ex_valid_i = 1'b0;
        @(negedge clock);
        bus.flush_i = 1'b0;
        #1;
        chk("b2b_flushed_busy", {63'd0, bus.busy_o}, 64'd0);

        // Flush on busy cycle 20 of a MUL: aborted, no result ever.
        @(negedge clock);
        bus.ex_valid_i  = 1'b1;
        bus.ex_opcode_i = OPC_MUL;
        bus.ex_reg1_i   = 64'd7;
        bus.ex_reg2_i   = 64'd9;
        bus.ex_waddr_i  = 5'd10;
        for (int k = 0; k < 20; k++) @(negedge clock);
        #1;
        chk("flush_busy_before", {63'd0, bus.busy_o}, 64'd1);
        bus.flush_i = 1'b1;
        @(negedge clock);
        bus.flush_i    = 1'b0;
        bus.ex_valid_i = 1'b0;
        #1;
        chk("flush_stall_after", {63'd0, bus.stall_o}, 64'd0);
        chk("flush_busy_after",  {63'd0, bus.busy_o}, 64'd0);
        nvalid = 0;
        for (int k = 0; k < 100; k++) begin
            if (bus.md_valid_o) nvalid++;
            @(negedge clock);
            #1;
        end
        chk("flush_no_valid", 64'(nvalid), 64'd0);
        v = '{"mul_2x2", OPC_MUL, 64'd2, 64'd2, 5'd8, 64'd4, 1'b0, 65};
        run_vec(v);

        // Flush together with a would-be start: not accepted.
        @(negedge clock);
        bus.ex_valid_i  = 1'b1;
        bus.ex_opcode_i = OPC_UDIV;
        bus.ex_reg1_i   = 64'd50;
        bus.ex_reg2_i   = 64'd5;
        bus.flush_i     = 1'b1;
        #1;
        chk("flush_start_stall", {63'd0, bus.stall_o}, 64'd0);
        @(negedge clock);
        idle_inputs();
        #1;
        chk("flush_start_busy", {63'd0, bus.busy_o}, 64'd0);

        // Asynchronous reset mid-DIV, between clock edges.
        @(negedge clock);
        bus.ex_valid_i  = 1'b1;
        bus.ex_opcode_i = OPC_UDIV;
        bus.ex_reg1_i   = 64'd100;
        bus.ex_reg2_i   = 64'd7;
        bus.ex_waddr_i  = 5'd3;
        for (int k = 0; k < 10; k++) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_stall",  {63'd0, bus.stall_o}, 64'd0);
        chk("arst_busy",   {63'd0, bus.busy_o}, 64'd0);
        chk("arst_valid",  {63'd0, bus.md_valid_o}, 64'd0);
        chk("arst_result", bus.md_result_o, 64'd0);
        chk("arst_waddr",  {59'd0, bus.md_waddr_o}, 64'd0);
        chk("arst_dbz",    {63'd0, bus.md_dbz_o}, 64'd0);
        idle_inputs();
        @(negedge clock);
        reset = 1'b1;
        v = '{"div_9_3", OPC_UDIV, 64'd9, 64'd3, 5'd5, 64'd3, 1'b0, 65};
        run_vec(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
